// File: rtl/fnd_scan_if.sv
// Pin bundle between board logic and the FND scan controller.
// The board side is the master; the controller is the slave.
interface fnd_scan_if #(
    parameter int DIGITS = 4
) ();
    logic                  en;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp;
    logic [DIGITS-1:0]     blank;
    logic [3:0]            bright;
    logic [DIGITS-1:0]     com;
    logic [7:0]            seg;
    logic                  frame_start;

    modport master (
        output en, value, dp, blank, bright,
        input  com, seg, frame_start
    );

    modport slave (
        input  en, value, dp, blank, bright,
        output com, seg, frame_start
    );
endinterface

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed 7-segment scan controller: per-frame input latch, hex font, dead time,
// 16-step PWM brightness, per-digit blanking and optional leading-zero suppression.
module fnd_scan_ctrl #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 125000,
    parameter int BLANK_CYC      = 1250,
    parameter bit LZ_BLANK       = 1'b0,
    parameter bit COM_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input logic       clk,
    input logic       rst,
    fnd_scan_if.slave bus
);
    localparam int                CW       = $clog2(SCAN_DIV);
    localparam int                IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [31:0]       BLANK_W  = 32'(BLANK_CYC);
    localparam logic [31:0]       ACTIVE_W = 32'(SCAN_DIV - BLANK_CYC);
    localparam logic [DIGITS-1:0] COM_OFF  = {DIGITS{COM_ACTIVE_LOW}};
    localparam logic [7:0]        SEG_OFF  = {8{SEG_ACTIVE_LOW}};

    function automatic logic [6:0] hex_font(input logic [3:0] n);
        case (n)
            4'h0:    hex_font = 7'h3F;
            4'h1:    hex_font = 7'h06;
            4'h2:    hex_font = 7'h5B;
            4'h3:    hex_font = 7'h4F;
            4'h4:    hex_font = 7'h66;
            4'h5:    hex_font = 7'h6D;
            4'h6:    hex_font = 7'h7D;
            4'h7:    hex_font = 7'h07;
            4'h8:    hex_font = 7'h7F;
            4'h9:    hex_font = 7'h6F;
            4'hA:    hex_font = 7'h77;
            4'hB:    hex_font = 7'h7C;
            4'hC:    hex_font = 7'h39;
            4'hD:    hex_font = 7'h5E;
            4'hE:    hex_font = 7'h79;
            default: hex_font = 7'h71;
        endcase
    endfunction

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] val_s_q, val_s_d;
    logic [DIGITS-1:0]   dp_s_q, dp_s_d;
    logic [DIGITS-1:0]   blank_s_q, blank_s_d;
    logic [3:0]          bright_s_q, bright_s_d;
    logic                first_q, first_d;
    logic                fs_q, fs_d;
    logic [DIGITS-1:0]   com_q, com_d;
    logic [7:0]          seg_q, seg_d;

    logic [3:0]  cur_nib;
    logic        lz_zero;
    logic        suppress;
    logic [31:0] cnt_w;
    logic        in_window;
    logic        lit;
    logic        slot_end;

    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        val_s_d    = val_s_q;
        dp_s_d     = dp_s_q;
        blank_s_d  = blank_s_q;
        bright_s_d = bright_s_q;
        first_d    = first_q;
        fs_d       = 1'b0;
        com_d      = COM_OFF;
        seg_d      = SEG_OFF;
        cur_nib    = 4'h0;
        lz_zero    = 1'b1;

        // A digit is a leading zero when it and every more significant digit are zero.
        for (int j = 0; j < DIGITS; j++) begin
            if (j <= int'(idx_q) && val_s_q[4*(DIGITS-1-j) +: 4] != 4'h0) lz_zero = 1'b0;
            if (j == int'(idx_q)) cur_nib = val_s_q[4*(DIGITS-1-j) +: 4];
        end
        suppress = LZ_BLANK && lz_zero && (idx_q != IW'(DIGITS-1));

        // PWM window: compare scaled offset against the bright-weighted active length.
        cnt_w     = 32'(cnt_q);
        in_window = (cnt_w >= BLANK_W) &&
                    (((cnt_w - BLANK_W) << 4) < ACTIVE_W * (32'(bright_s_q) + 32'd1));
        lit       = in_window && !blank_s_q[idx_q] && !suppress;
        slot_end  = (cnt_q == CW'(SCAN_DIV - 1));

        if (bus.en) begin
            if (slot_end) begin
                cnt_d = '0;
                idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            if (first_q || (slot_end && idx_q == IW'(DIGITS - 1))) begin
                val_s_d    = bus.value;
                dp_s_d     = bus.dp;
                blank_s_d  = bus.blank;
                bright_s_d = bus.bright;
                first_d    = 1'b0;
                fs_d       = 1'b1;
            end
            if (lit) begin
                com_d[idx_q] = ~COM_OFF[idx_q];
                seg_d        = {dp_s_q[idx_q], hex_font(cur_nib)} ^ SEG_OFF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            val_s_q    <= '0;
            dp_s_q     <= '0;
            blank_s_q  <= '0;
            bright_s_q <= '0;
            first_q    <= 1'b1;
            fs_q       <= 1'b0;
            com_q      <= COM_OFF;
            seg_q      <= SEG_OFF;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            val_s_q    <= val_s_d;
            dp_s_q     <= dp_s_d;
            blank_s_q  <= blank_s_d;
            bright_s_q <= bright_s_d;
            first_q    <= first_d;
            fs_q       <= fs_d;
            com_q      <= com_d;
            seg_q      <= seg_d;
        end
    end

    assign bus.com         = com_q;
    assign bus.seg         = seg_q;
    assign bus.frame_start = fs_q;
endmodule
